// File: rtl/vc_test_rand_delay_sink.sv
// Random-backpressure val/rdy test sink: checks each accepted message against a
// preloaded expected table and stalls a pseudo-random number of cycles between accepts.
module vc_test_rand_delay_sink #(
    parameter int p_msg_nbits = 1,
    parameter int p_num_msgs  = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            max_delay,
    input  logic                   load_val,
    input  logic [p_msg_nbits-1:0] load_msg,
    input  logic                   val,
    output logic                   rdy,
    input  logic [p_msg_nbits-1:0] msg,
    output logic                   done,
    output logic                   err,
    output logic [31:0]            err_idx,
    output logic [31:0]            num_errors
);

    localparam int          ADDR_W_C    = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
    localparam logic [31:0] NUM_MSGS_C  = 32'(p_num_msgs);
    localparam logic [31:0] LFSR_SEED_C = 32'hACE1_ACE1;
    localparam logic [31:0] LFSR_MASK_C = 32'h8020_0003;

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_DELAY = 1'b1
    } state_t;

    // Right-shifting Galois step; the mask is folded in when a one falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        if (cur[0]) begin
            return {1'b0, cur[31:1]} ^ LFSR_MASK_C;
        end else begin
            return {1'b0, cur[31:1]};
        end
    endfunction

    logic [p_msg_nbits-1:0] mem_r [p_num_msgs];

    state_t      state_r, state_nxt_s;
    logic [31:0] cnt_r, cnt_nxt_s;
    logic [31:0] load_count_r, load_count_nxt_s;
    logic [31:0] check_idx_r, check_idx_nxt_s;
    logic [31:0] lfsr_r, lfsr_nxt_s;
    logic        rdy_r, rdy_nxt_s;
    logic        done_r, done_nxt_s;
    logic        err_r, err_nxt_s;
    logic [31:0] err_idx_r, err_idx_nxt_s;
    logic [31:0] num_errors_r, num_errors_nxt_s;

    logic                   xfer_s;
    logic                   load_ok_s;
    logic                   mismatch_s;
    logic [p_msg_nbits-1:0] exp_msg_s;
    logic [32:0]            divisor_s;
    logic [31:0]            draw_s;

    assign rdy        = rdy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign err_idx    = err_idx_r;
    assign num_errors = num_errors_r;

    // Handshake, table lookup, random draw and next-state computation.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        xfer_s           = val && rdy_r;
        load_ok_s        = load_val && (load_count_r < NUM_MSGS_C);
        exp_msg_s        = mem_r[check_idx_r[ADDR_W_C-1:0]];
        mismatch_s       = xfer_s && (msg != exp_msg_s);
        // 33-bit divisor keeps max_delay = all-ones from wrapping to zero.
        divisor_s        = {1'b0, max_delay} + 33'd1;
        draw_s           = 32'({1'b0, lfsr_r} % divisor_s);
        load_count_nxt_s = load_ok_s ? (load_count_r + 32'd1) : load_count_r;
        check_idx_nxt_s  = xfer_s ? (check_idx_r + 32'd1) : check_idx_r;
        lfsr_nxt_s       = xfer_s ? lfsr_next(lfsr_r) : lfsr_r;

        case (state_r)
            ST_READY: begin
                if (xfer_s && (draw_s != 32'd0)) begin
                    state_nxt_s = ST_DELAY;
                    cnt_nxt_s   = draw_s - 32'd1;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            ST_DELAY: begin
                if (cnt_r == 32'd0) begin
                    state_nxt_s = ST_READY;
                end else begin
                    cnt_nxt_s = cnt_r - 32'd1;
                end
            end
            default: begin
                state_nxt_s = ST_READY;
                cnt_nxt_s   = 32'd0;
            end
        endcase

        rdy_nxt_s  = (state_nxt_s == ST_READY) && (check_idx_nxt_s < load_count_nxt_s);
        done_nxt_s = (load_count_nxt_s != 32'd0) && (check_idx_nxt_s == load_count_nxt_s);

        err_nxt_s     = mismatch_s;
        err_idx_nxt_s = mismatch_s ? check_idx_r : err_idx_r;
        if (mismatch_s && (num_errors_r != 32'hFFFF_FFFF)) begin
            num_errors_nxt_s = num_errors_r + 32'd1;
        end else begin
            num_errors_nxt_s = num_errors_r;
        end
    end

    // Control, counter and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_READY;
            cnt_r        <= 32'd0;
            load_count_r <= 32'd0;
            check_idx_r  <= 32'd0;
            lfsr_r       <= LFSR_SEED_C;
            rdy_r        <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            err_idx_r    <= 32'd0;
            num_errors_r <= 32'd0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            load_count_r <= load_count_nxt_s;
            check_idx_r  <= check_idx_nxt_s;
            lfsr_r       <= lfsr_nxt_s;
            rdy_r        <= rdy_nxt_s;
            done_r       <= done_nxt_s;
            err_r        <= err_nxt_s;
            err_idx_r    <= err_idx_nxt_s;
            num_errors_r <= num_errors_nxt_s;
        end
    end

    // Expected-message table; contents survive reset, only the counters clear.
    always_ff @(posedge clk) begin
        if (load_ok_s) begin
            mem_r[load_count_r[ADDR_W_C-1:0]] <= load_msg;
        end
    end

endmodule

// File: tb/tb_vc_test_rand_delay_sink.sv
// Directed self-checking bench for vc_test_rand_delay_sink (8-bit messages, 128-deep table).
module tb_vc_test_rand_delay_sink;

    localparam int NB = 8;
    localparam int NM = 128;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   max_delay;
    logic          load_val;
    logic [NB-1:0] load_msg;
    logic          val;
    logic          rdy;
    logic [NB-1:0] msg;
    logic          done;
    logic          err;
    logic [31:0]   err_idx;
    logic [31:0]   num_errors;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NB-1:0] tx[$];
    int            xfer_cyc[$];
    logic          err_after[$];
    int            err_hits;
    int            xfers;

    always #5 clk = ~clk;

    vc_test_rand_delay_sink #(.p_msg_nbits(NB), .p_num_msgs(NM)) dut (
        .clk(clk), .reset_n(reset_n), .max_delay(max_delay),
        .load_val(load_val), .load_msg(load_msg),
        .val(val), .rdy(rdy), .msg(msg),
        .done(done), .err(err), .err_idx(err_idx), .num_errors(num_errors)
    );

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [31:0] model_draw(input logic [31:0] s, input logic [31:0] md);
        longint unsigned q;
        q = longint'(s) % (longint'(md) + 64'd1);
        return q[31:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        load_val  = 1'b0;
        load_msg  = '0;
        val       = 1'b0;
        msg       = '0;
        max_delay = 32'd0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic load_one(input logic [NB-1:0] v);
        load_val = 1'b1;
        load_msg = v;
        tick();
        load_val = 1'b0;
    endtask

    // Source presenting tx[] back-to-back; records the cycle of each transfer.
    task automatic run_stream(input int budget);
        int  k;
        bit  hs;
        k = 0;
        err_hits = 0;
        xfer_cyc.delete();
        err_after.delete();
        for (int c = 0; c < budget && k < tx.size(); c++) begin
            val = 1'b1;
            msg = tx[k];
            hs  = (rdy === 1'b1);
            tick();
            if (err === 1'b1) err_hits++;
            if (hs) begin
                xfer_cyc.push_back(c);
                err_after.push_back(err);
                k++;
            end
        end
        val   = 1'b0;
        msg   = '0;
        xfers = k;
    endtask

    // Number of stall gaps that disagree with the seed-driven draw sequence.
    function automatic int gap_errors(input logic [31:0] md);
        logic [31:0] l;
        int          bad;
        l   = 32'hACE1_ACE1;
        bad = 0;
        for (int i = 0; i + 1 < xfer_cyc.size(); i++) begin
            if (xfer_cyc[i+1] - xfer_cyc[i] - 1 != int'(model_draw(l, md))) bad++;
            l = model_step(l);
        end
        return bad;
    endfunction

    task automatic test_reset;
        reset_n = 1'b1;
        load_val = 1'b0; load_msg = '0; val = 1'b0; msg = '0; max_delay = 32'd0;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({rdy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {rdy, done, err}); end
        n_cmp++; if (err_idx !== 32'd0) begin n_bad++; $display("FAIL reset_err_idx got %h want 0", err_idx); end
        n_cmp++; if (num_errors !== 32'd0) begin n_bad++; $display("FAIL reset_num_errors got %h want 0", num_errors); end
        apply_reset();
        repeat (3) tick();
        n_cmp++; if ({rdy, done} !== 2'b00) begin n_bad++; $display("FAIL empty_idle got rdy,done=%b want 00", {rdy, done}); end
    endtask

    task automatic test_zero_delay;
        apply_reset();
        load_one(8'h01);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL load_to_ready got %b want 1", rdy); end
        load_one(8'h02); load_one(8'h03); load_one(8'h04);
        tx = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_stream(20);
        n_cmp++; if (xfers !== 4) begin n_bad++; $display("FAIL zd_xfers got %0d want 4", xfers); end
        n_cmp++; if (xfers == 4 && xfer_cyc[3] - xfer_cyc[0] !== 3) begin n_bad++; $display("FAIL zd_back_to_back got span %0d want 3", xfer_cyc[3] - xfer_cyc[0]); end
        n_cmp++; if ({done, rdy, err_hits != 0} !== 3'b100) begin n_bad++; $display("FAIL zd_end got done,rdy,errseen=%b want 100", {done, rdy, err_hits != 0}); end
        n_cmp++; if (num_errors !== 32'd0) begin n_bad++; $display("FAIL zd_num_errors got %0d want 0", num_errors); end
    endtask

    task automatic test_mismatch;
        apply_reset();
        load_one(8'h0A); load_one(8'h0B); load_one(8'h0C);
        tx = '{8'h0A, 8'h0F, 8'h0C};
        run_stream(20);
        n_cmp++; if (xfers !== 3) begin n_bad++; $display("FAIL mm_xfers got %0d want 3", xfers); end
        n_cmp++; if (xfers == 3 && {err_after[0], err_after[1], err_after[2]} !== 3'b010) begin n_bad++; $display("FAIL mm_err_pulse got %b want 010", {err_after[0], err_after[1], err_after[2]}); end
        n_cmp++; if (err_hits !== 1) begin n_bad++; $display("FAIL mm_err_count got %0d want 1", err_hits); end
        n_cmp++; if (err_idx !== 32'd1) begin n_bad++; $display("FAIL mm_err_idx got %0d want 1", err_idx); end
        n_cmp++; if (num_errors !== 32'd1) begin n_bad++; $display("FAIL mm_num_errors got %0d want 1", num_errors); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mm_done got %b want 1", done); end
    endtask

    task automatic test_random_stalls;
        int max_gap;
        for (int run = 0; run < 2; run++) begin
            apply_reset();
            max_delay = 32'd3;
            tx.delete();
            for (int i = 0; i < 100; i++) begin
                tx.push_back(NB'(i * 7));
                load_one(NB'(i * 7));
            end
            run_stream(1000);
            max_gap = 0;
            for (int i = 0; i + 1 < xfer_cyc.size(); i++)
                if (xfer_cyc[i+1] - xfer_cyc[i] - 1 > max_gap) max_gap = xfer_cyc[i+1] - xfer_cyc[i] - 1;
            n_cmp++; if (xfers !== 100) begin n_bad++; $display("FAIL rs%0d_xfers got %0d want 100", run, xfers); end
            n_cmp++; if (max_gap > 3) begin n_bad++; $display("FAIL rs%0d_max_stall got %0d want <=3", run, max_gap); end
            n_cmp++; if (gap_errors(32'd3) !== 0) begin n_bad++; $display("FAIL rs%0d_stall_seq got %0d bad gaps want 0", run, gap_errors(32'd3)); end
            n_cmp++; if ({done, num_errors == 32'd0} !== 2'b11) begin n_bad++; $display("FAIL rs%0d_end got done=%b nerr=%0d want 1,0", run, done, num_errors); end
        end
    endtask

    task automatic test_overrun_append;
        apply_reset();
        load_one(8'h11); load_one(8'h22);
        tx = '{8'h11, 8'h22, 8'h33};
        run_stream(10);
        n_cmp++; if (xfers !== 2) begin n_bad++; $display("FAIL ov_xfers got %0d want 2", xfers); end
        val = 1'b1; msg = 8'h33;
        tick();
        n_cmp++; if ({rdy, done} !== 2'b01) begin n_bad++; $display("FAIL ov_held got rdy,done=%b want 01", {rdy, done}); end
        load_one(8'h33);
        n_cmp++; if ({rdy, done} !== 2'b10) begin n_bad++; $display("FAIL ov_append got rdy,done=%b want 10", {rdy, done}); end
        tick();
        val = 1'b0;
        n_cmp++; if ({rdy, done, err} !== 3'b010 || num_errors !== 32'd0) begin n_bad++; $display("FAIL ov_accept got rdy,done,err=%b nerr=%0d want 010,0", {rdy, done, err}, num_errors); end
    endtask

    task automatic test_reset_midstream;
        apply_reset();
        max_delay = 32'd3;
        for (int i = 0; i < 10; i++) load_one(NB'(8'h40 + i));
        tx = '{8'h40, 8'h41, 8'h99, 8'h43, 8'h44};
        run_stream(100);
        n_cmp++; if (xfers !== 5 || num_errors !== 32'd1) begin n_bad++; $display("FAIL rm_pre got xfers=%0d nerr=%0d want 5,1", xfers, num_errors); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({rdy, done, err} !== 3'b000 || num_errors !== 32'd0 || err_idx !== 32'd0) begin n_bad++; $display("FAIL rm_async got rdy,done,err=%b nerr=%0d eidx=%0d want 000,0,0", {rdy, done, err}, num_errors, err_idx); end
        tick();
        reset_n = 1'b1;
        tick();
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL rm_table_empty got rdy=%b want 0", rdy); end
        max_delay = 32'd3;
        tx.delete();
        for (int i = 0; i < 10; i++) begin
            tx.push_back(NB'(8'h40 + i));
            load_one(NB'(8'h40 + i));
        end
        run_stream(200);
        n_cmp++; if (xfers == 10 && xfer_cyc[1] - xfer_cyc[0] - 1 !== 1) begin n_bad++; $display("FAIL rm_first_draw got %0d want 1", xfer_cyc[1] - xfer_cyc[0] - 1); end
        n_cmp++; if (xfers !== 10 || gap_errors(32'd3) !== 0 || done !== 1'b1 || num_errors !== 32'd0) begin n_bad++; $display("FAIL rm_resend got xfers=%0d badgaps=%0d done=%b nerr=%0d want 10,0,1,0", xfers, gap_errors(32'd3), done, num_errors); end
    endtask

    task automatic test_boundary;
        apply_reset();
        tx.delete();
        for (int i = 0; i <= NM; i++) begin
            tx.push_back((i == NM) ? 8'hEE : NB'(i));
            load_one((i == NM) ? 8'hEE : NB'(i));
        end
        run_stream(300);
        n_cmp++; if (xfers !== NM) begin n_bad++; $display("FAIL bd_capacity got %0d xfers want %0d", xfers, NM); end
        n_cmp++; if ({rdy, done} !== 2'b01 || num_errors !== 32'd0) begin n_bad++; $display("FAIL bd_full_end got rdy,done=%b nerr=%0d want 01,0", {rdy, done}, num_errors); end

        apply_reset();
        max_delay = 32'hFFFF_FFFF;
        load_one(8'h05); load_one(8'h06);
        tx = '{8'h05, 8'h06};
        run_stream(30);
        n_cmp++; if (xfers !== 1 || rdy !== 1'b0) begin n_bad++; $display("FAIL bd_max_delay got xfers=%0d rdy=%b want 1,0", xfers, rdy); end
        max_delay = 32'd0;
        repeat (5) tick();
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL bd_delay_keeps_count got rdy=%b want 0", rdy); end
    endtask

    initial begin
        test_reset();
        test_zero_delay();
        test_mismatch();
        test_random_stalls();
        test_overrun_append();
        test_reset_midstream();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
